// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU controller: FSM states, instruction
// field positions, destination bits, jump codes and ALU comp codes.
package hack_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MREAD  = 3'd2,
        EXEC   = 3'd3,
        MWRITE = 3'd4
    } state_e;

    localparam int IS_C    = 15;
    localparam int A_BIT   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    localparam int DEST_A = 5;
    localparam int DEST_D = 4;
    localparam int DEST_M = 3;

    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

    // Comp codes as (zx,nx,zy,ny,f,no); x is D, y is A or M.
    localparam logic [5:0] C_ZERO  = 6'b101010;
    localparam logic [5:0] C_ONE   = 6'b111111;
    localparam logic [5:0] C_NEG1  = 6'b111010;
    localparam logic [5:0] C_X     = 6'b001100;
    localparam logic [5:0] C_Y     = 6'b110000;
    localparam logic [5:0] C_NOTX  = 6'b001101;
    localparam logic [5:0] C_NOTY  = 6'b110001;
    localparam logic [5:0] C_NEGX  = 6'b001111;
    localparam logic [5:0] C_NEGY  = 6'b110011;
    localparam logic [5:0] C_XP1   = 6'b011111;
    localparam logic [5:0] C_YP1   = 6'b110111;
    localparam logic [5:0] C_XM1   = 6'b001110;
    localparam logic [5:0] C_YM1   = 6'b110010;
    localparam logic [5:0] C_XPY   = 6'b000010;
    localparam logic [5:0] C_XMY   = 6'b010011;
    localparam logic [5:0] C_YMX   = 6'b000111;
    localparam logic [5:0] C_XANDY = 6'b000000;
    localparam logic [5:0] C_XORY  = 6'b010101;

    function automatic logic reads_m(input logic [15:0] ir);
        return ir[IS_C] & ir[A_BIT];
    endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// Jump condition evaluation from a 3-bit jump code and the ALU result.
module hack_jump_eval
    import hack_pkg::*;
(
    input  logic [2:0]  jump_i,
    input  logic [15:0] value_i,
    output logic        take_o
);
    logic zr;
    logic ng;

    assign zr     = (value_i == 16'h0000);
    assign ng     = value_i[15];
    assign take_o = (jump_i[2] & ng) | (jump_i[1] & zr) | (jump_i[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetch, decode, optional M read, execute on
// the external ALU, optional M write, commit. Owns A, D, PC and IR.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    input  logic [15:0]       dmem_rdata,
    input  logic              dmem_valid,
    output logic [15:0]       alu_x,
    output logic [15:0]       alu_y,
    output logic [5:0]        alu_c,
    input  logic [15:0]       alu_out,
    output logic [ADDR_W-1:0] pc_o,
    output logic [15:0]       a_o,
    output logic [15:0]       d_o,
    output logic              retire
);
    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       a_q, d_q, ir_q, r_q;
    logic              take_q;
    logic              imem_req_q, dmem_req_q, dmem_we_q, retire_q;
    logic [15:0]       alu_x_q, alu_y_q;
    logic [5:0]        alu_c_q;

    logic              take_exec;
    logic              take_d;
    logic [15:0]       r_d;
    logic              commit_d;

    hack_jump_eval u_jump (
        .jump_i  (ir_q[JUMP_HI:JUMP_LO]),
        .value_i (alu_out),
        .take_o  (take_exec)
    );

    // Commit happens either straight out of EXEC or when the M write completes.
    assign r_d      = (state_q == EXEC) ? alu_out   : r_q;
    assign take_d   = (state_q == EXEC) ? take_exec : take_q;
    assign commit_d = ((state_q == EXEC) && !ir_q[DEST_M]) ||
                      ((state_q == MWRITE) && dmem_req_q && dmem_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= PC_RESET;
            a_q        <= '0;
            d_q        <= '0;
            ir_q       <= '0;
            r_q        <= '0;
            take_q     <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            retire_q   <= 1'b0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            alu_c_q    <= '0;
        end else begin
            retire_q <= 1'b0;
            if (commit_d) begin
                if (ir_q[DEST_A]) a_q <= r_d;
                if (ir_q[DEST_D]) d_q <= r_d;
                pc_q       <= take_d ? a_q[ADDR_W-1:0] : pc_q + PC_ONE;
                retire_q   <= 1'b1;
                imem_req_q <= 1'b1;
                dmem_req_q <= 1'b0;
                dmem_we_q  <= 1'b0;
                state_q    <= FETCH;
            end else begin
                case (state_q)
                    FETCH: begin
                        // First cycle out of reset raises the request.
                        if (!imem_req_q) begin
                            imem_req_q <= 1'b1;
                        end else if (imem_valid) begin
                            ir_q       <= imem_rdata;
                            imem_req_q <= 1'b0;
                            state_q    <= DECODE;
                        end
                    end
                    DECODE: begin
                        if (!ir_q[IS_C]) begin
                            a_q        <= {1'b0, ir_q[14:0]};
                            pc_q       <= pc_q + PC_ONE;
                            retire_q   <= 1'b1;
                            imem_req_q <= 1'b1;
                            state_q    <= FETCH;
                        end else if (reads_m(ir_q)) begin
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= 1'b0;
                            state_q    <= MREAD;
                        end else begin
                            alu_c_q <= ir_q[COMP_HI:COMP_LO];
                            alu_x_q <= d_q;
                            alu_y_q <= a_q;
                            state_q <= EXEC;
                        end
                    end
                    MREAD: begin
                        if (dmem_req_q && dmem_valid) begin
                            dmem_req_q <= 1'b0;
                            alu_c_q    <= ir_q[COMP_HI:COMP_LO];
                            alu_x_q    <= d_q;
                            alu_y_q    <= dmem_rdata;
                            state_q    <= EXEC;
                        end
                    end
                    EXEC: begin
                        r_q        <= alu_out;
                        take_q     <= take_exec;
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= 1'b1;
                        state_q    <= MWRITE;
                    end
                    MWRITE: begin
                    end
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = a_q[ADDR_W-1:0];
    assign dmem_wdata = r_q;
    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_c      = alu_c_q;
    assign pc_o       = pc_q;
    assign a_o        = a_q;
    assign d_o        = d_q;
    assign retire     = retire_q;

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Multi-cycle control/datapath sequencer for the 16-bit Hack-style CPU. It is the driving end of the Alu16 interface.
- It fetches instructions, decodes C-instructions into the 6-bit ALU control word (zx,nx,zy,ny,f,no), feeds the x/y operands and captures the result.
- It evaluates jumps, and owns the A, D and PC registers.
- It talks to instruction and data memory over req/valid handshakes.

Parameters:
- PC_RESET, 15'd0, PC value loaded on reset
- ADDR_W, 15, instruction/data address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_rdata  in  16  instruction word
- imem_valid  in  1  fetch completes this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  data address (= A[14:0])
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data
- dmem_valid  in  1  data access completes this cycle
- alu_x  out  16  ALU operand x (= D)
- alu_y  out  16  ALU operand y (A or M)
- alu_c  out  6  ALU control word
- alu_out  in  16  ALU result (combinational)
- pc_o, a_o, d_o  out  15/16/16  architectural state, for debug
- retire  out  1  one-cycle pulse per completed instruction

Behaviour:
- Reset (async, rst_n = 0):
  - PC = PC_RESET; A = D = 0; IR = 0; state = FETCH.
  - All req/we/retire = 0; alu_c = 0; alu_x = alu_y = 0.
  - When reset is asserted mid-transaction, req drops immediately. A valid arriving after reset is ignored.
- Handshake (both memories):
  - req is held high, with addr/we/wdata stable, until valid = 1 is sampled while req = 1. The transaction completes that edge.
  - req deasserts the following cycle. Zero-wait response (valid in the first req cycle) is legal.
  - valid while req = 0 is ignored.
- States:
  - FETCH: imem_req = 1, imem_addr = PC. On imem_valid, IR <= imem_rdata, go to DECODE.
  - DECODE:
    - IR[15] = 0 (A-instruction): A <= {1'b0, IR[14:0]}, PC <= PC + 1, retire = 1, go to FETCH.
    - IR[15] = 1 and IR[12] = 1: go to MREAD.
    - Otherwise: go to EXEC.
  - MREAD: dmem_req = 1, we = 0, addr = A. On dmem_valid, M <= dmem_rdata, go to EXEC.
  - EXEC (exactly 1 cycle):
    - alu_c = IR[11:6], alu_x = D, alu_y = IR[12] ? M : A.
    - R <= alu_out. zr = (alu_out == 0), ng = alu_out[15]. Flags are computed here, not taken from the ALU.
    - take = (IR[2] & ng) | (IR[1] & zr) | (IR[0] & !ng & !zr).
    - If IR[3] (dest M): go to MWRITE. Otherwise commit and go to FETCH.
  - MWRITE: dmem_req = 1, we = 1, addr = A (old A), wdata = R. On dmem_valid, commit and go to FETCH.
- Commit (single edge):
  - if IR[5], A <= R; if IR[4], D <= R.
  - PC <= take ? A_old[14:0] : PC + 1.
  - retire = 1.
- Ordering rules:
  - Jump target and M address always use A as it was before this instruction; A is updated at commit.
- Boundary and arithmetic rules:
  - PC wraps at 2^15 - 1 → 0.
  - IR[14:13] are ignored.
  - Comp codes not supported by the ALU are passed through unchanged. The controller uses whatever alu_out returns.
  - Jump code 000 never jumps; 111 always jumps.
- alu_c/alu_x/alu_y are only meaningful in EXEC. Outside EXEC they hold their last values.
- Latency (zero-wait memory):
  - A-instruction: 2 cycles.
  - Plain C-instruction: 3 cycles.
  - Each M read or M write adds at least 1 cycle.

Decomposition:
- Package hack_pkg:
  - State enum.
  - IR field positions: IS_C = 15, A_BIT = 12, COMP 11:6, DEST 5:3, JUMP 2:0.
  - Dest bit names.
  - Jump code constants (JGT = 001 … JMP = 111).
  - Named comp constants matching the ALU table.
- Sub-module hack_jump_eval: combinational; inputs jump[2:0] and value[15:0], output take.

Test Plan:
1. @5 (0x0005), D=A (0xEC10), zero-wait memories → after the second retire: D = 5, PC = 2, alu_c = 110000 in EXEC, dmem_req never asserted.
2. @3, D=M (0xFC10); dmem_valid arrives 2 cycles after req with rdata 0x1234 → dmem_addr = 3, we = 0, D = 0x1234, req high for exactly 3 cycles.
3. D = 0xBEEF loaded, then @7, M=D (0xE308) → one write with addr 7 and wdata 0xBEEF; A and D unchanged; PC advances by 1.
4. @0x10, 0;JMP (0xEA87) → PC = 0x10. Then D = 0 with D;JEQ (0xE302) → jump taken. Then D = 0xFFFF with the same JEQ → PC + 1.
5. A = 0x20, M[0x20] = 0x0041, AM=M+1 (0xFDE8) → write addr 0x20, wdata 0x0042, then A = 0x0042.
6. rst_n low for 1 cycle during MREAD, with valid arriving afterwards → req drops asynchronously, PC = PC_RESET, late valid ignored, next fetch at address 0.
